// File: rtl/pc_branch_unit_if.sv
// Opcode masks shared by the branch unit and its bus bundle, plus the interface
// carrying instruction/operand inputs and PC/RAS status outputs.
package opcodes;
  typedef logic [31:0] instruction_t;

  localparam instruction_t MASK_J  = 32'h0000_007f;
  localparam instruction_t MASK_F3 = 32'h0000_707f;

  localparam instruction_t M_JAL  = 32'h0000_006f;
  localparam instruction_t M_JALR = 32'h0000_0067;
  localparam instruction_t M_BEQ  = 32'h0000_0063;
  localparam instruction_t M_BNE  = 32'h0000_1063;
  localparam instruction_t M_BLT  = 32'h0000_4063;
  localparam instruction_t M_BGE  = 32'h0000_5063;
  localparam instruction_t M_BLTU = 32'h0000_6063;
  localparam instruction_t M_BGEU = 32'h0000_7063;
endpackage

interface pc_branch_unit_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  import opcodes::*;

  instruction_t                   instr;
  logic [XLEN-1:0]                op1;
  logic [XLEN-1:0]                op2;
  logic [XLEN-1:0]                op3;
  logic                           enable;
  logic                           step;
  logic [XLEN-1:0]                pc_out;
  logic [XLEN-1:0]                ret_addr;
  logic                           taken;
  logic                           trap;
  logic [XLEN-1:0]                epc;
  logic [$clog2(RAS_DEPTH):0]     ras_count;
  logic                           ras_mispredict;

  modport master (
    output instr, op1, op2, op3, enable, step,
    input  pc_out, ret_addr, taken, trap, epc, ras_count, ras_mispredict
  );

  modport slave (
    input  instr, op1, op2, op3, enable, step,
    output pc_out, ret_addr, taken, trap, epc, ras_count, ras_mispredict
  );
endinterface

// File: rtl/pc_branch_unit.sv
// Program counter and control-transfer unit: resolves JAL/JALR and conditional
// branches, traps on misaligned targets and checks returns against a small RAS.
module pc_branch_unit
  import opcodes::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] TRAP_PC   = 'h100,
  parameter int              RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  pc_branch_unit_if.slave   bus
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ret_q, ret_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            taken_q, taken_d;
  logic            trap_q, trap_d;
  logic            misp_q, misp_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  logic            isJal, isJalr, isBeq, isBne, isBlt, isBge, isBltu, isBgeu;
  logic [4:0]      rd, rs1;
  logic            rdLink, rs1Link;
  logic [XLEN-1:0] pcPlus4, target, topEntry;
  logic            cond, redirect, misaligned;
  logic            doPush, doPop, popValid;
  logic [PW-1:0]   ptrAfterPop;
  logic [CW-1:0]   cntAfterPop;

  always_comb begin
    isJal   = (bus.instr & MASK_J)  == M_JAL;
    isJalr  = (bus.instr & MASK_F3) == M_JALR;
    isBeq   = (bus.instr & MASK_F3) == M_BEQ;
    isBne   = (bus.instr & MASK_F3) == M_BNE;
    isBlt   = (bus.instr & MASK_F3) == M_BLT;
    isBge   = (bus.instr & MASK_F3) == M_BGE;
    isBltu  = (bus.instr & MASK_F3) == M_BLTU;
    isBgeu  = (bus.instr & MASK_F3) == M_BGEU;
    rd      = bus.instr[11:7];
    rs1     = bus.instr[19:15];
    rdLink  = (rd == 5'd1) || (rd == 5'd5);
    rs1Link = (rs1 == 5'd1) || (rs1 == 5'd5);
    pcPlus4 = pc_q + XLEN'(4);

    target = pc_q + bus.op3;
    cond   = 1'b0;
    if (isJal) begin
      target = bus.op1;
      cond   = 1'b1;
    end else if (isJalr) begin
      target = (bus.op1 + bus.op2) & ~XLEN'(1);
      cond   = 1'b1;
    end else if (isBeq) begin
      cond = bus.op1 == bus.op2;
    end else if (isBne) begin
      cond = bus.op1 != bus.op2;
    end else if (isBlt) begin
      cond = $signed(bus.op1) < $signed(bus.op2);
    end else if (isBge) begin
      cond = $signed(bus.op1) >= $signed(bus.op2);
    end else if (isBltu) begin
      cond = bus.op1 < bus.op2;
    end else if (isBgeu) begin
      cond = bus.op1 >= bus.op2;
    end

    redirect   = bus.step && bus.enable && cond;
    misaligned = target[1:0] != 2'b00;

    // A JALR linking through a different register both returns and calls.
    doPush   = redirect && !misaligned && (isJal || isJalr) && rdLink;
    doPop    = redirect && !misaligned && isJalr && rs1Link && (!rdLink || rd != rs1);
    popValid = doPop && (cnt_q != '0);
    topEntry = ras_q[ptr_q - PW'(1)];

    ptrAfterPop = popValid ? ptr_q - PW'(1) : ptr_q;
    cntAfterPop = popValid ? cnt_q - CW'(1) : cnt_q;
  end

  always_comb begin
    pc_d    = pc_q;
    ret_d   = ret_q;
    epc_d   = epc_q;
    taken_d = 1'b0;
    trap_d  = 1'b0;
    misp_d  = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (bus.step) begin
      if (redirect && misaligned) begin
        pc_d   = TRAP_PC;
        epc_d  = pc_q;
        trap_d = 1'b1;
      end else begin
        pc_d    = redirect ? target : pcPlus4;
        taken_d = redirect;
        if (bus.enable) ret_d = pcPlus4;
        misp_d = popValid && (topEntry != target);
        ptr_d  = ptrAfterPop;
        cnt_d  = cntAfterPop;
        if (doPush) begin
          ptr_d = ptrAfterPop + PW'(1);
          cnt_d = (cntAfterPop == CW'(RAS_DEPTH)) ? cntAfterPop : cntAfterPop + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      ret_q   <= '0;
      epc_q   <= '0;
      taken_q <= 1'b0;
      trap_q  <= 1'b0;
      misp_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      epc_q   <= epc_d;
      taken_q <= taken_d;
      trap_q  <= trap_d;
      misp_q  <= misp_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // When full, the write pointer sits on the oldest entry, so a push overwrites it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else if (doPush) begin
      ras_q[ptrAfterPop] <= pcPlus4;
    end
  end

  assign bus.pc_out         = pc_q;
  assign bus.ret_addr       = ret_q;
  assign bus.epc            = epc_q;
  assign bus.taken          = taken_q;
  assign bus.trap           = trap_q;
  assign bus.ras_mispredict = misp_q;
  assign bus.ras_count      = cnt_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Randomized and directed bench for pc_branch_unit against a queue-based
// behavioural model of the PC, link, trap and return-address-stack rules.
module tb_pc_branch_unit;
  localparam int          XLEN      = 32;
  localparam int          RAS_DEPTH = 4;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam logic [31:0] TRAP_PC   = 32'h100;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pc_branch_unit_if #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) bus ();

  pc_branch_unit #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .TRAP_PC(TRAP_PC), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state, kept in architectural terms.
  logic [31:0] mPc, mRet, mEpc;
  logic        mTaken, mTrap, mMisp;
  logic [31:0] mRas[$];

  function automatic logic [31:0] mkJal(input logic [4:0] rd);
    return {20'h0, rd, 7'h6f};
  endfunction

  function automatic logic [31:0] mkJalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h0, rs1, 3'b000, rd, 7'h67};
  endfunction

  function automatic logic [31:0] mkBr(input logic [2:0] f3);
    return {17'h0, f3, 5'h0, 7'h63};
  endfunction

  function automatic bit isLink(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  task automatic modelReset();
    mPc = RESET_PC; mRet = '0; mEpc = '0;
    mTaken = 0; mTrap = 0; mMisp = 0;
    mRas.delete();
  endtask

  task automatic modelStep(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] off, input bit en, input bit st);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1;
    logic [31:0] t, link, top;
    bit          isJ, isJr, c, pop;
    mTaken = 0; mTrap = 0; mMisp = 0;
    if (!st) return;
    opc = ins[6:0]; f3 = ins[14:12]; rd = ins[11:7]; rs1 = ins[19:15];
    isJ  = (opc == 7'h6f);
    isJr = (opc == 7'h67) && (f3 == 3'd0);
    link = mPc + 32'd4;
    t = mPc + off;
    c = 0;
    if (isJ) begin
      t = a; c = 1;
    end else if (isJr) begin
      t = a + b; t[0] = 1'b0; c = 1;
    end else if (opc == 7'h63) begin
      case (f3)
        3'd0: c = (a == b);
        3'd1: c = (a != b);
        3'd4: c = ($signed(a) <  $signed(b));
        3'd5: c = ($signed(a) >= $signed(b));
        3'd6: c = (a <  b);
        3'd7: c = (a >= b);
        default: c = 0;
      endcase
    end
    if (en && c && t[1:0] != 2'b00) begin
      mEpc = mPc; mPc = TRAP_PC; mTrap = 1;
      return;
    end
    if (en) mRet = link;
    if (en && c) begin
      mTaken = 1;
      if (isJ || isJr) begin
        pop = isJr && isLink(rs1) && (!isLink(rd) || rd != rs1);
        if (pop && mRas.size() > 0) begin
          top = mRas.pop_back();
          if (top != t) mMisp = 1;
        end
        if (isLink(rd)) begin
          if (mRas.size() == RAS_DEPTH) void'(mRas.pop_front());
          mRas.push_back(link);
        end
      end
      mPc = t;
    end else begin
      mPc = link;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".pc"},    64'(bus.pc_out),         64'(mPc));
    checkOutput({tag, ".ret"},   64'(bus.ret_addr),       64'(mRet));
    checkOutput({tag, ".epc"},   64'(bus.epc),            64'(mEpc));
    checkOutput({tag, ".taken"}, 64'(bus.taken),          64'(mTaken));
    checkOutput({tag, ".trap"},  64'(bus.trap),           64'(mTrap));
    checkOutput({tag, ".misp"},  64'(bus.ras_mispredict), 64'(mMisp));
    checkOutput({tag, ".cnt"},   64'(bus.ras_count),      64'(mRas.size()));
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] ins, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] off,
                               input bit en, input bit st);
    @(negedge clk);
    bus.instr = ins; bus.op1 = a; bus.op2 = b; bus.op3 = off;
    bus.enable = en; bus.step = st;
    modelStep(ins, a, b, off, en, st);
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    bus.step = 0; bus.enable = 0;
    rst = 0;
    modelReset();
    #1;
    checkAll(tag);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic nop(input string tag);
    applyStimulus(tag, 32'h13, 0, 0, 0, 0, 1);
  endtask

  initial begin
    logic [31:0] ins, a, b, off;
    logic [4:0]  rd, rs1;
    int          kind;
    errors = 0; checks = 0;
    rst = 1;
    bus.instr = '0; bus.op1 = '0; bus.op2 = '0; bus.op3 = '0;
    bus.enable = 0; bus.step = 0;
    #2;
    doReset("reset");

    nop("seq0"); nop("seq1"); nop("seq2");
    checkOutput("seq.pcC", 64'(bus.pc_out), 64'h0c);
    checkOutput("seq.ret0", 64'(bus.ret_addr), 64'h0);

    doReset("rst2");
    nop("n0"); nop("n1");
    applyStimulus("blt", mkBr(3'd4), 32'hffff_ffff, 32'd1, 32'd16, 1, 1);
    checkOutput("blt.pc24", 64'(bus.pc_out), 64'd24);
    checkOutput("blt.taken", 64'(bus.taken), 64'd1);

    doReset("rst3");
    nop("n2"); nop("n3");
    applyStimulus("bltu", mkBr(3'd6), 32'hffff_ffff, 32'd1, 32'd16, 1, 1);
    checkOutput("bltu.pc12", 64'(bus.pc_out), 64'd12);
    checkOutput("bltu.ret12", 64'(bus.ret_addr), 64'd12);

    applyStimulus("toPc40", mkJal(5'd0), 32'h40, 0, 0, 1, 1);
    applyStimulus("jalr201", mkJalr(5'd0, 5'd2), 32'h201, 0, 0, 1, 1);
    checkOutput("jalr.pc200", 64'(bus.pc_out), 64'h200);
    applyStimulus("jalr202", mkJalr(5'd0, 5'd2), 32'h202, 0, 0, 1, 1);
    checkOutput("trap.pc", 64'(bus.pc_out), 64'(TRAP_PC));
    checkOutput("trap.epc", 64'(bus.epc), 64'h200);
    checkOutput("trap.ret", 64'(bus.ret_addr), 64'h44);
    checkOutput("trap.pulse", 64'(bus.trap), 64'd1);

    applyStimulus("toPc10", mkJal(5'd0), 32'h10, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++)
      applyStimulus("call", mkJal(5'd1), 32'h20 + 32'(i) * 32'h10, 0, 0, 1, 1);
    checkOutput("ras.full", 64'(bus.ras_count), 64'd4);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("ret", mkJalr(5'd0, 5'd1), 32'h54 - 32'(i) * 32'h10, 0, 0, 1, 1);
      checkOutput("ret.nomisp", 64'(bus.ras_mispredict), 64'd0);
    end
    checkOutput("ras.empty", 64'(bus.ras_count), 64'd0);

    applyStimulus("toPc100", mkJal(5'd0), 32'h100, 0, 0, 1, 1);
    applyStimulus("push104", mkJal(5'd1), 32'h300, 0, 0, 1, 1);
    applyStimulus("badret", mkJalr(5'd0, 5'd1), 32'h108, 0, 0, 1, 1);
    checkOutput("misp.pulse", 64'(bus.ras_mispredict), 64'd1);
    checkOutput("misp.pc", 64'(bus.pc_out), 64'h108);
    nop("afterMisp");
    checkOutput("misp.cleared", 64'(bus.ras_mispredict), 64'd0);

    applyStimulus("hold", mkBr(3'd0), 32'h5, 32'h5, 32'h40, 1, 0);
    applyStimulus("hold2", mkBr(3'd0), 32'h5, 32'h5, 32'h40, 1, 0);
    applyStimulus("pushMid", mkJal(5'd5), 32'h800, 0, 0, 1, 1);
    doReset("midReset");
    checkOutput("midReset.pc", 64'(bus.pc_out), 64'(RESET_PC));
    checkOutput("midReset.cnt", 64'(bus.ras_count), 64'd0);

    for (int n = 0; n < 600; n++) begin
      kind = $urandom_range(0, 9);
      a = $urandom(); b = $urandom(); off = $urandom();
      rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 7) != 0) begin
        a[1:0] = 2'b00; b[1:0] = 2'b00; off[1:0] = 2'b00;
      end
      if ($urandom_range(0, 3) == 0) b = a;
      case (kind)
        0:       ins = $urandom();
        1, 2, 3: ins = mkBr(3'($urandom_range(0, 7)));
        4, 5:    ins = mkJal(rd);
        6, 7, 8: begin
          ins = mkJalr(rd, rs1);
          if ($urandom_range(0, 1) == 1 && mRas.size() > 0) begin
            a = mRas[mRas.size() - 1]; b = 0;
          end
        end
        default: ins = 32'h13;
      endcase
      applyStimulus("rand", ins, a, b, off, $urandom_range(0, 5) != 0,
                    $urandom_range(0, 9) != 0);
      if ($urandom_range(0, 150) == 0) doReset("randReset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Parametrised program-counter and control-transfer unit, the next generation of the core's branch unit. Holds the architectural PC, resolves JAL/JALR and the six conditional branches on operands supplied by the decode/register stage, and advances one instruction per `step`. New over the previous generation:
- configurable width and reset/trap vectors;
- misaligned-target trap with captured EPC;
- return-address stack (RAS) that checks every return against its prediction.

## Interface
- `XLEN`, 32: data/address width; all operands and PCs are `XLEN` bits.
- `RESET_PC`, 0: PC value after reset.
- `TRAP_PC`, 'h100: PC loaded on a misaligned-target trap.
- `RAS_DEPTH`, 4: return-address stack entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low (asserted at 0).
- `instr`  in  instruction_t  current instruction; decoded with the `opcodes` masks M_JAL, M_JALR, M_BEQ, M_BNE, M_BLT, M_BLTU, M_BGE, M_BGEU; rd = instr[11:7], rs1 = instr[19:15].
- `op1`, `op2`, `op3`  in  XLEN  JAL target / JALR base / compare operand A; JALR offset / compare operand B; branch offset.
- `enable`  in  1  instruction is a control transfer; when 0 the PC steps sequentially.
- `step`  in  1  advance one instruction this cycle; no state changes when 0.
- `pc_out`  out  XLEN  current PC (direct from register).
- `ret_addr`  out  XLEN  link value (PC+4) of the last enabled, non-trapping step.
- `taken`  out  1  pulse: last step redirected the PC (jump or taken branch).
- `trap`  out  1  pulse: last step took the misaligned-target trap.
- `epc`  out  XLEN  PC of the instruction that trapped.
- `ras_count`  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- `ras_mispredict`  out  1  pulse: last pop predicted a target different from the resolved one.

## Operation
- Decode: on `step` with `enable`=1, compute target T and condition C.
  - JAL: T = op1, C = 1.
  - JALR: T = (op1+op2) with bit 0 cleared, C = 1.
  - Branches: T = pc+op3. BEQ/BNE compare for equality; BLT/BGE compare signed; BLTU/BGEU compare unsigned.
  - An unmatched instr behaves as not taken.
- All additions are modulo 2^XLEN; carries are discarded.
- Not taken (C=0 or `enable`=0): pc ← pc+4. `enable`=1 also sets ret_addr ← pc+4.
- Taken, T[1:0]==0: pc ← T, ret_addr ← pc+4, `taken` pulses.
- Taken, T[1:0]≠0: pc ← TRAP_PC, epc ← pc, `trap` pulses. ret_addr, `taken` and the RAS are unchanged. A not-taken branch never traps.
- Link register means rd or rs1 ∈ {1,5}. RAS updates only on a taken, non-trapping JAL/JALR:
  - Push pc+4 when rd is a link register.
  - Pop on JALR when rs1 is a link register and rd is not.
  - JALR with both rd and rs1 link and rd≠rs1: pop then push. With rd==rs1: push only.
  - Pop on non-empty RAS: compare the top entry with T; `ras_mispredict` pulses if they differ. The PC always follows T, never the prediction.
  - Pop on empty RAS: no compare, no pulse, count stays 0.
  - Push on full RAS: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.

## Timing
- Reset (async assert, sync release to next edge): pc_out=RESET_PC; ret_addr, epc = 0; taken, trap, ras_mispredict = 0; ras_count = 0.
- Reset asserted mid-operation discards all in-flight state immediately, including RAS contents.
- Latency is one cycle: the values from the `step` edge are visible after that edge.
- `taken`, `trap` and `ras_mispredict` are high for exactly the one cycle following their step, then return low.
- `step`=0 holds every register. `enable` and the operands are ignored without `step`.
- pc_out is registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset then 3 cycles with step=1, enable=0 → pc_out 0→4→8→'hC; ret_addr stays 0; no pulses.
- pc=8, BLT with op1=-1, op2=1, op3=16 → pc=24, taken=1. Same operands with BLTU → pc=12, taken=0, ret_addr=12.
- pc=0x40, JALR with op1=0x201, op2=0 → pc=0x200 (bit 0 cleared), taken=1. Then JALR with op1=0x202, op2=0 → pc=TRAP_PC, trap=1, epc=0x200, ret_addr unchanged at 0x44.
- RAS_DEPTH=4: five JALs with rd=1 from pc 0x10,0x20,0x30,0x40,0x50 (pushes 0x14…0x54) → ras_count=4. Five returns (JALR, rs1=1, rd=0) to 0x54,0x44,0x34,0x24,0x14 → first four show no ras_mispredict; fifth is an empty pop with no pulse and count 0.
- Push 0x104, then return resolving to 0x108 → ras_mispredict=1 for one cycle; pc=0x108.
- step=0 while enable=1 with a taken BEQ → all outputs held. Assert rst mid-stream → pc_out=RESET_PC immediately, ras_count=0.
